timer_prescaler: RTL and testbench
==================================

# timer_prescaler

Programmable, parametrised prescaler for the general-purpose timer. It generates a single-cycle `tick_o` strobe once every (PSC+1) counted units. A unit is either a clock cycle (clock mode) or an input event strobe (event mode, replacing the fixed 1/2/4/8 capture prescale). The ratio is double-buffered: a preload register transfers to the active register only on counter wrap or a software update, so ratio changes never truncate a period. It sits between the timer clock/capture front-end and the main counter or capture logic.

## Interface
- `PSC_W`, default 16: width of ratio and counter. Divide ratio range is 1 .. 2^PSC_W.
- `clk_i`  in  1  timer clock.
- `aresetn_i`  in  1  reset, synchronous, active-low.
- `cce_i`  in  1  counter enable. Low: counter frozen, no ticks.
- `mode_i`  in  1  0 = count clock cycles, 1 = count `evt_i` strobes.
- `evt_i`  in  1  single-cycle event strobe, used in event mode only.
- `psc_i`  in  PSC_W  new ratio minus one.
- `psc_wr_i`  in  1  write strobe: `psc_i` → preload register.
- `ug_i`  in  1  update generation: immediate reload and counter clear.
- `tick_o`  out  1  registered single-cycle strobe on wrap.
- `cnt_o`  out  PSC_W  current prescaler count.
- `psc_act_o`  out  PSC_W  active ratio minus one.
- `upd_pend_o`  out  1  preload written, not yet transferred.

## Operation
- Reset (`aresetn_i`=0 at a clock edge) clears `cnt`, `psc_pre`, `psc_act`, `tick_o` and `upd_pend_o` to 0. The reset state is divide-by-1.
- Counting unit: `inc = cce_i & (mode_i ? evt_i : 1)`.
- Priority, highest first: reset, then `ug_i`, then `inc`.
- `ug_i`=1:
  - `cnt` ← 0 and `psc_act` ← `psc_pre`.
  - No tick is generated.
  - Acts regardless of `cce_i`.
- `inc`=1 and `cnt == psc_act`:
  - `cnt` ← 0.
  - `tick_o` is 1 next cycle.
  - `psc_act` ← `psc_pre` (the update event).
- `inc`=1 otherwise: `cnt` ← `cnt` + 1.
- `inc`=0: `cnt` holds.
- `psc_wr_i`=1: `psc_pre` ← `psc_i` and `upd_pend_o` ← 1. Accepted whether or not `cce_i` is set.
- Transfer (`ug_i` or wrap) clears `upd_pend_o`.
- Simultaneous `psc_wr_i` and transfer in the same cycle:
  - `psc_act` takes the old `psc_pre`.
  - `psc_pre` takes `psc_i`.
  - `upd_pend_o` remains 1, so the new ratio applies at the following wrap.
- Invariant: `cnt` ≤ `psc_act` always holds, because `psc_act` changes only when `cnt` is cleared. Comparison is equality only; there is no wrap past 2^PSC_W−1.
- `psc_act` = 0:
  - Every counted unit produces a tick.
  - In clock mode with `cce_i` held high, `tick_o` is continuously 1.
- `mode_i` change: applies from the next counted unit. `cnt` is not cleared; software issues `ug_i` when a clean start is needed.

## Timing
- `tick_o` latency: 1 cycle after the cycle in which the wrapping `inc` is sampled.
- Tick period in clock mode is exactly `psc_act`+1 cycles while `cce_i` is high.
- `cnt_o`, `psc_act_o` and `upd_pend_o` are register outputs and reflect updates the cycle after the causing edge.
- `cce_i` deasserted: `tick_o` is 0 from the next cycle, except for a tick already launched by the last enabled cycle.
- `ug_i` coincident with a wrapping `inc`: `ug_i` wins and no tick is produced.
- Reset mid-period: any pending tick is dropped, and the preload and pending state are lost.
- Event mode: `evt_i` is a strobe sampled every cycle. Back-to-back strobes count as separate units.

## Structure
- `timer_pkg` holds:
  - `PSC_W_DEF` = 16.
  - `typedef enum logic {PSC_MODE_CLK, PSC_MODE_EVT} psc_mode_e`.
- Sub-module `timer_preload_reg`, parametrised on width:
  - Contents: preload register, active register and pending flag, with the simultaneous write/transfer rule above.
  - Reused for the ARR/CCR shadow registers.
- Top level contains the counter, the `inc` logic and the tick register.

## Test plan
- Reset, `cce_i`=1, clock mode, no write → `tick_o`=1 every cycle starting the cycle after reset release; `cnt_o` stays 0.
- `psc_i`=3 with `psc_wr_i`, then `ug_i` → `psc_act_o`=3 and `upd_pend_o`=0. Ticks follow every 4 cycles; `cnt_o` runs 0,1,2,3,0.
- While dividing by 4, write `psc_i`=1 at `cnt`=1 → `upd_pend_o`=1. The current period completes at 4 cycles, then the period is 2 and `upd_pend_o` returns to 0.
- Write `psc_i`=5 in the exact wrap cycle of a divide-by-4 run → one more period of 4, then periods of 6.
- Event mode, `psc_act`=2, 9 `evt_i` strobes with random gaps and `cce_i` dropped for 5 cycles midway → exactly 3 ticks, each 1 cycle after the 3rd/6th/9th strobe; `cnt_o` frozen while `cce_i`=0.
- `ug_i` asserted in the same cycle as a wrap, and `aresetn_i` pulsed at `cnt`=2 → no tick in the `ug_i` case, and `cnt_o`=0. The reset returns all outputs to 0 on the next edge.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared types and defaults for the general-purpose timer blocks.
package timer_pkg;

  localparam int PSC_W_DEF = 16;

  typedef enum logic {PSC_MODE_CLK, PSC_MODE_EVT} psc_mode_e;

endpackage

// File: rtl/timer_preload_reg.sv
// Double-buffered register: software writes the preload copy, the active copy
// follows only on a transfer. Shared by the prescaler and the ARR/CCR shadows.
module timer_preload_reg
  import timer_pkg::*;
#(
  parameter int WIDTH = PSC_W_DEF
) (
  input  logic             clk_i,
  input  logic             aresetn_i,
  input  logic             wr_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             xfer_i,
  output logic [WIDTH-1:0] act_o,
  output logic             pend_o
);

  logic [WIDTH-1:0] pre_r;
  logic [WIDTH-1:0] act_r;
  logic             pend_r;

  // Preload/active/pending update; a write coincident with a transfer lands
  // in preload after the old preload has moved to active, so it stays pending.
  always_ff @(posedge clk_i) begin
    if (!aresetn_i) begin
      pre_r  <= {WIDTH{1'b0}};
      act_r  <= {WIDTH{1'b0}};
      pend_r <= 1'b0;
    end else begin
      if (xfer_i) begin
        act_r <= pre_r;
      end else begin
        act_r <= act_r;
      end
      if (wr_i) begin
        pre_r  <= data_i;
        pend_r <= 1'b1;
      end else if (xfer_i) begin
        pre_r  <= pre_r;
        pend_r <= 1'b0;
      end else begin
        pre_r  <= pre_r;
        pend_r <= pend_r;
      end
    end
  end

  assign act_o  = act_r;
  assign pend_o = pend_r;

endmodule

// File: rtl/timer_prescaler.sv
// Timer prescaler: emits a one-cycle tick every (psc_act+1) clock cycles or
// event strobes, with a double-buffered ratio so changes never cut a period.
module timer_prescaler
  import timer_pkg::*;
#(
  parameter int PSC_W = PSC_W_DEF
) (
  input  logic             clk_i,
  input  logic             aresetn_i,
  input  logic             cce_i,
  input  logic             mode_i,
  input  logic             evt_i,
  input  logic [PSC_W-1:0] psc_i,
  input  logic             psc_wr_i,
  input  logic             ug_i,
  output logic             tick_o,
  output logic [PSC_W-1:0] cnt_o,
  output logic [PSC_W-1:0] psc_act_o,
  output logic             upd_pend_o
);

  psc_mode_e        mode_s;
  logic             inc_s;
  logic             at_top_s;
  logic             wrap_s;
  logic             xfer_s;
  logic [PSC_W-1:0] psc_act_s;
  logic [PSC_W-1:0] cnt_r;
  logic             tick_r;

  assign mode_s = psc_mode_e'(mode_i);

  // Select the counted unit: every enabled clock, or every enabled event strobe.
  always_comb begin
    inc_s = 1'b0;
    case (mode_s)
      PSC_MODE_CLK: inc_s = cce_i;
      PSC_MODE_EVT: inc_s = cce_i & evt_i;
      default:      inc_s = 1'b0;
    endcase
  end

  // Equality is enough: cnt never exceeds psc_act since the ratio only
  // changes when the counter is cleared.
  assign at_top_s = (cnt_r == psc_act_s);
  assign wrap_s   = inc_s & at_top_s & ~ug_i;
  assign xfer_s   = ug_i | wrap_s;

  timer_preload_reg #(
    .WIDTH (PSC_W)
  ) u_psc_reg (
    .clk_i     (clk_i),
    .aresetn_i (aresetn_i),
    .wr_i      (psc_wr_i),
    .data_i    (psc_i),
    .xfer_i    (xfer_s),
    .act_o     (psc_act_s),
    .pend_o    (upd_pend_o)
  );

  // Counter and tick register; update generation clears without ticking.
  always_ff @(posedge clk_i) begin
    if (!aresetn_i) begin
      cnt_r  <= {PSC_W{1'b0}};
      tick_r <= 1'b0;
    end else if (ug_i) begin
      cnt_r  <= {PSC_W{1'b0}};
      tick_r <= 1'b0;
    end else if (wrap_s) begin
      cnt_r  <= {PSC_W{1'b0}};
      tick_r <= 1'b1;
    end else if (inc_s) begin
      cnt_r  <= cnt_r + {{(PSC_W-1){1'b0}}, 1'b1};
      tick_r <= 1'b0;
    end else begin
      cnt_r  <= cnt_r;
      tick_r <= 1'b0;
    end
  end

  assign tick_o    = tick_r;
  assign cnt_o     = cnt_r;
  assign psc_act_o = psc_act_s;

endmodule

// File: tb/tb_timer_prescaler.sv
// Directed bench for timer_prescaler: inputs change and outputs are checked
// on the falling edge, so each check sees the state after the previous rise.
module tb_timer_prescaler;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         aresetn;
  logic         cce;
  logic         mode;
  logic         evt;
  logic [W-1:0] psc;
  logic         psc_wr;
  logic         ug;
  logic         tick_o;
  logic [W-1:0] cnt_o;
  logic [W-1:0] psc_act_o;
  logic         upd_pend_o;

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  timer_prescaler #(.PSC_W(W)) dut (
    .clk_i      (clk),
    .aresetn_i  (aresetn),
    .cce_i      (cce),
    .mode_i     (mode),
    .evt_i      (evt),
    .psc_i      (psc),
    .psc_wr_i   (psc_wr),
    .ug_i       (ug),
    .tick_o     (tick_o),
    .cnt_o      (cnt_o),
    .psc_act_o  (psc_act_o),
    .upd_pend_o (upd_pend_o)
  );

  task automatic test_reset();
    aresetn = 1'b0; cce = 1'b1; mode = 1'b0; evt = 1'b0;
    psc = '0; psc_wr = 1'b0; ug = 1'b0;
    repeat (2) @(negedge clk);
    checks += 4;
    if (tick_o !== 1'b0) begin errs++; $display("FAIL reset_tick got %0b exp 0", tick_o); end
    if (cnt_o !== 16'd0) begin errs++; $display("FAIL reset_cnt got %0d exp 0", cnt_o); end
    if (psc_act_o !== 16'd0) begin errs++; $display("FAIL reset_act got %0d exp 0", psc_act_o); end
    if (upd_pend_o !== 1'b0) begin errs++; $display("FAIL reset_pend got %0b exp 0", upd_pend_o); end
    aresetn = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks += 2;
      if (tick_o !== 1'b1) begin errs++; $display("FAIL div1_tick cyc %0d got %0b exp 1", k, tick_o); end
      if (cnt_o !== 16'd0) begin errs++; $display("FAIL div1_cnt cyc %0d got %0d exp 0", k, cnt_o); end
    end
  endtask

  task automatic test_ug_load();
    int ec[8] = '{1, 2, 3, 0, 1, 2, 3, 0};
    cce = 1'b0; psc_wr = 1'b1; psc = 16'd3;
    @(negedge clk);
    psc_wr = 1'b0;
    checks += 2;
    if (upd_pend_o !== 1'b1) begin errs++; $display("FAIL wr_pend got %0b exp 1", upd_pend_o); end
    if (psc_act_o !== 16'd0) begin errs++; $display("FAIL wr_act_held got %0d exp 0", psc_act_o); end
    ug = 1'b1;
    @(negedge clk);
    ug = 1'b0;
    checks += 4;
    if (psc_act_o !== 16'd3) begin errs++; $display("FAIL ug_act got %0d exp 3", psc_act_o); end
    if (upd_pend_o !== 1'b0) begin errs++; $display("FAIL ug_pend got %0b exp 0", upd_pend_o); end
    if (cnt_o !== 16'd0) begin errs++; $display("FAIL ug_cnt got %0d exp 0", cnt_o); end
    if (tick_o !== 1'b0) begin errs++; $display("FAIL ug_tick got %0b exp 0", tick_o); end
    cce = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks += 2;
      if (cnt_o !== W'(ec[k])) begin errs++; $display("FAIL div4_cnt cyc %0d got %0d exp %0d", k, cnt_o, ec[k]); end
      if (tick_o !== (ec[k] == 0)) begin errs++; $display("FAIL div4_tick cyc %0d got %0b exp %0b", k, tick_o, ec[k] == 0); end
    end
  endtask

  task automatic test_write_mid();
    int ec[6] = '{3, 0, 1, 0, 1, 0};
    @(negedge clk);
    checks++;
    if (cnt_o !== 16'd1) begin errs++; $display("FAIL mid_cnt1 got %0d exp 1", cnt_o); end
    psc_wr = 1'b1; psc = 16'd1;
    @(negedge clk);
    psc_wr = 1'b0;
    checks += 3;
    if (cnt_o !== 16'd2) begin errs++; $display("FAIL mid_cnt2 got %0d exp 2", cnt_o); end
    if (upd_pend_o !== 1'b1) begin errs++; $display("FAIL mid_pend got %0b exp 1", upd_pend_o); end
    if (psc_act_o !== 16'd3) begin errs++; $display("FAIL mid_act_old got %0d exp 3", psc_act_o); end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks += 2;
      if (cnt_o !== W'(ec[k])) begin errs++; $display("FAIL mid_cnt cyc %0d got %0d exp %0d", k, cnt_o, ec[k]); end
      if (tick_o !== (ec[k] == 0)) begin errs++; $display("FAIL mid_tick cyc %0d got %0b exp %0b", k, tick_o, ec[k] == 0); end
      if (k == 1) begin
        checks += 2;
        if (psc_act_o !== 16'd1) begin errs++; $display("FAIL mid_act_new got %0d exp 1", psc_act_o); end
        if (upd_pend_o !== 1'b0) begin errs++; $display("FAIL mid_pend_clr got %0b exp 0", upd_pend_o); end
      end
    end
  endtask

  task automatic test_wrap_write();
    int ec[10] = '{1, 2, 3, 0, 1, 2, 3, 4, 5, 0};
    cce = 1'b0; psc_wr = 1'b1; psc = 16'd3;
    @(negedge clk);
    psc_wr = 1'b0; ug = 1'b1;
    @(negedge clk);
    ug = 1'b0; cce = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (cnt_o !== W'(k + 1)) begin errs++; $display("FAIL ww_ramp cyc %0d got %0d exp %0d", k, cnt_o, k + 1); end
    end
    psc_wr = 1'b1; psc = 16'd5;
    @(negedge clk);
    psc_wr = 1'b0;
    checks += 4;
    if (cnt_o !== 16'd0) begin errs++; $display("FAIL ww_cnt got %0d exp 0", cnt_o); end
    if (tick_o !== 1'b1) begin errs++; $display("FAIL ww_tick got %0b exp 1", tick_o); end
    if (psc_act_o !== 16'd3) begin errs++; $display("FAIL ww_act got %0d exp 3", psc_act_o); end
    if (upd_pend_o !== 1'b1) begin errs++; $display("FAIL ww_pend got %0b exp 1", upd_pend_o); end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks += 2;
      if (cnt_o !== W'(ec[k])) begin errs++; $display("FAIL ww_cnt cyc %0d got %0d exp %0d", k, cnt_o, ec[k]); end
      if (tick_o !== (ec[k] == 0)) begin errs++; $display("FAIL ww_tick cyc %0d got %0b exp %0b", k, tick_o, ec[k] == 0); end
      if (k == 3) begin
        checks += 2;
        if (psc_act_o !== 16'd5) begin errs++; $display("FAIL ww_act_new got %0d exp 5", psc_act_o); end
        if (upd_pend_o !== 1'b0) begin errs++; $display("FAIL ww_pend_clr got %0b exp 0", upd_pend_o); end
      end
    end
  endtask

  task automatic test_event();
    logic ev[20] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1,
                     1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic ce[20] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                     1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    int ec[20] = '{1, 1, 2, 0, 0, 1, 1, 1, 1, 1, 1, 2, 0, 0, 0, 1, 2, 2, 0, 0};
    logic et[20] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                     1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    int ticks = 0;
    cce = 1'b0; psc_wr = 1'b1; psc = 16'd2;
    @(negedge clk);
    psc_wr = 1'b0; ug = 1'b1;
    @(negedge clk);
    ug = 1'b0; mode = 1'b1;
    for (int c = 0; c < 20; c++) begin
      evt = ev[c]; cce = ce[c];
      @(negedge clk);
      if (tick_o === 1'b1) ticks++;
      checks += 2;
      if (cnt_o !== W'(ec[c])) begin errs++; $display("FAIL evt_cnt cyc %0d got %0d exp %0d", c, cnt_o, ec[c]); end
      if (tick_o !== et[c]) begin errs++; $display("FAIL evt_tick cyc %0d got %0b exp %0b", c, tick_o, et[c]); end
    end
    evt = 1'b0;
    checks++;
    if (ticks != 3) begin errs++; $display("FAIL evt_tick_count got %0d exp 3", ticks); end
  endtask

  task automatic test_ug_wrap_reset();
    mode = 1'b0; cce = 1'b1;
    @(negedge clk);
    checks++;
    if (cnt_o !== 16'd1) begin errs++; $display("FAIL ugw_cnt1 got %0d exp 1", cnt_o); end
    @(negedge clk);
    checks++;
    if (cnt_o !== 16'd2) begin errs++; $display("FAIL ugw_cnt2 got %0d exp 2", cnt_o); end
    ug = 1'b1;
    @(negedge clk);
    ug = 1'b0;
    checks += 4;
    if (tick_o !== 1'b0) begin errs++; $display("FAIL ugw_tick got %0b exp 0", tick_o); end
    if (cnt_o !== 16'd0) begin errs++; $display("FAIL ugw_cnt got %0d exp 0", cnt_o); end
    if (psc_act_o !== 16'd2) begin errs++; $display("FAIL ugw_act got %0d exp 2", psc_act_o); end
    if (upd_pend_o !== 1'b0) begin errs++; $display("FAIL ugw_pend got %0b exp 0", upd_pend_o); end
    psc_wr = 1'b1; psc = 16'd7;
    @(negedge clk);
    psc_wr = 1'b0;
    checks += 2;
    if (cnt_o !== 16'd1) begin errs++; $display("FAIL rst_pre_cnt got %0d exp 1", cnt_o); end
    if (upd_pend_o !== 1'b1) begin errs++; $display("FAIL rst_pre_pend got %0b exp 1", upd_pend_o); end
    @(negedge clk);
    checks++;
    if (cnt_o !== 16'd2) begin errs++; $display("FAIL rst_pre_cnt2 got %0d exp 2", cnt_o); end
    aresetn = 1'b0;
    @(negedge clk);
    aresetn = 1'b1;
    checks += 4;
    if (tick_o !== 1'b0) begin errs++; $display("FAIL rst_tick got %0b exp 0", tick_o); end
    if (cnt_o !== 16'd0) begin errs++; $display("FAIL rst_cnt got %0d exp 0", cnt_o); end
    if (psc_act_o !== 16'd0) begin errs++; $display("FAIL rst_act got %0d exp 0", psc_act_o); end
    if (upd_pend_o !== 1'b0) begin errs++; $display("FAIL rst_pend got %0b exp 0", upd_pend_o); end
    @(negedge clk);
    checks += 3;
    if (tick_o !== 1'b1) begin errs++; $display("FAIL post_rst_tick got %0b exp 1", tick_o); end
    if (psc_act_o !== 16'd0) begin errs++; $display("FAIL post_rst_act got %0d exp 0", psc_act_o); end
    if (upd_pend_o !== 1'b0) begin errs++; $display("FAIL post_rst_pend got %0b exp 0", upd_pend_o); end
  endtask

  initial begin
    test_reset();
    test_ug_load();
    test_write_mid();
    test_wrap_write();
    test_event();
    test_ug_wrap_reset();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
